// File: rtl/z80bus_sram_responder.sv
// rtl/z80bus_sram_responder.sv - Z80 bus slave driving an async 64Kx8 SRAM with wait states
// Optional write-protected low region is acked without touching the SRAM.
module z80bus_sram_responder #(
    parameter int          READ_WAIT  = 2,
    parameter int          WRITE_WAIT = 2,
    parameter logic [15:0] WP_TOP     = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_dat,
    output logic [7:0]  o_dat,
    input  logic        i_we,
    input  logic        i_cs,
    output logic        o_ack,
    output logic        o_busy,
    output logic [15:0] o_sram_addr,
    output logic [7:0]  o_sram_dq,
    output logic        o_sram_dq_oe,
    input  logic [7:0]  i_sram_dq,
    output logic        o_sram_ce_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_we_n
);

    if (READ_WAIT < 1 || READ_WAIT > 15) begin : g_bad_read_wait
        $error("READ_WAIT must be in 1..15");
    end
    if (WRITE_WAIT < 1 || WRITE_WAIT > 15) begin : g_bad_write_wait
        $error("WRITE_WAIT must be in 1..15");
    end

    localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD,
        S_WAITREL
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdat_q, wdat_d;
    logic        we_q, we_d;
    logic        wp_q, wp_d;
    logic [7:0]  rdat_q, rdat_d;
    logic [15:0] sram_addr_q, sram_addr_d;
    logic [7:0]  sram_dq_q, sram_dq_d;
    logic        dq_oe_q, dq_oe_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        wp_hit;
    logic        active_d;

    // A zero WP_TOP must not produce an always-false unsigned compare.
    if (WP_TOP == 16'h0000) begin : g_no_wp
        assign wp_hit = 1'b0;
    end else begin : g_wp
        assign wp_hit = (i_addr < WP_TOP);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        wp_d    = wp_q;
        rdat_d  = rdat_q;

        case (state_q)
            S_IDLE: begin
                if (i_cs) begin
                    addr_d  = i_addr;
                    wdat_d  = i_dat;
                    we_d    = i_we;
                    wp_d    = i_we && wp_hit;
                    state_d = (i_we && wp_hit) ? S_HOLD : S_SETUP;
                end
            end
            S_SETUP: begin
                if (!i_cs) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ACCESS;
                    cnt_d   = we_q ? WR_LOAD : RD_LOAD;
                end
            end
            S_ACCESS: begin
                if (!i_cs) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                    if (!we_q) begin
                        rdat_d = i_sram_dq;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                state_d = S_WAITREL;
            end
            S_WAITREL: begin
                if (!i_cs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pin values are decoded from the next state so every output is a flop.
        active_d = ((state_d == S_SETUP) || (state_d == S_ACCESS) || (state_d == S_HOLD)) && !wp_d;
        ce_n_d   = !active_d;
        oe_n_d   = !((state_d == S_ACCESS) && !we_d);
        we_n_d   = !((state_d == S_ACCESS) && we_d);
        dq_oe_d  = active_d && we_d;
        ack_d    = (state_d == S_HOLD);
        busy_d   = (state_d != S_IDLE);

        sram_addr_d = sram_addr_q;
        sram_dq_d   = sram_dq_q;
        if (state_d == S_SETUP) begin
            sram_addr_d = addr_d;
            if (we_d) begin
                sram_dq_d = wdat_d;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 16'h0000;
            wdat_q      <= 8'h00;
            we_q        <= 1'b0;
            wp_q        <= 1'b0;
            rdat_q      <= 8'h00;
            sram_addr_q <= 16'h0000;
            sram_dq_q   <= 8'h00;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            we_q        <= we_d;
            wp_q        <= wp_d;
            rdat_q      <= rdat_d;
            sram_addr_q <= sram_addr_d;
            sram_dq_q   <= sram_dq_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
        end
    end

    assign o_dat        = rdat_q;
    assign o_ack        = ack_q;
    assign o_busy       = busy_q;
    assign o_sram_addr  = sram_addr_q;
    assign o_sram_dq    = sram_dq_q;
    assign o_sram_dq_oe = dq_oe_q;
    assign o_sram_ce_n  = ce_n_q;
    assign o_sram_oe_n  = oe_n_q;
    assign o_sram_we_n  = we_n_q;

endmodule

// File: doc/z80bus_sram_responder.md
Name: z80bus_sram_responder

Overview:
- Bus responder (slave) on the Z80 computer's external memory bus: serves the o_addr/o_dat/o_we/o_cs request and returns data and a single-cycle ack.
- Converts each request into a timed access on an external asynchronous 64Kx8 SRAM, with configurable wait states.
- Provides an optional write-protected low region (boot ROM image) that is acked but not written.
- Sits between the computer's bus outputs and the board SRAM pins.

Parameters:
- READ_WAIT, 2, cycles oe_n held low per read; legal range 1..15.
- WRITE_WAIT, 2, cycles we_n held low per write; legal range 1..15.
- WP_TOP, 16'h0000, writes to addresses < WP_TOP are suppressed; 0 disables protection.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous reset, active low
- i_addr  in  16  bus address, from master o_addr
- i_dat  in  8  bus write data, from master o_dat
- o_dat  out  8  bus read data, to master i_dat
- i_we  in  1  1 = write, 0 = read
- i_cs  in  1  request; master holds addr/dat/we stable while high
- o_ack  out  1  one-cycle completion pulse, to master i_ack
- o_busy  out  1  high in any state except IDLE
- o_sram_addr  out  16  SRAM address
- o_sram_dq  out  8  SRAM write data
- o_sram_dq_oe  out  1  tristate enable for the SRAM data pins
- i_sram_dq  in  8  SRAM read data
- o_sram_ce_n  out  1  SRAM chip enable, active low
- o_sram_oe_n  out  1  SRAM output enable, active low
- o_sram_we_n  out  1  SRAM write enable, active low

Behaviour:
- All outputs are registered.
- Reset (async, immediate):
  - state = IDLE.
  - ce_n = oe_n = we_n = 1.
  - dq_oe = 0, o_ack = 0, o_busy = 0.
  - o_dat = 0, o_sram_addr = 0, o_sram_dq = 0.
  - Reset during any state releases all strobes at once; no ack is issued.
- States: IDLE, SETUP, ACCESS, HOLD, WAITREL.
- IDLE:
  - On an edge with i_cs = 1, latch i_addr, i_dat and i_we.
  - Protected write (i_we = 1 and i_addr < WP_TOP): go to HOLD. No SRAM strobes; the SRAM is not touched.
  - Otherwise: go to SETUP.
- SETUP (1 cycle):
  - ce_n = 0, o_sram_addr = latched address.
  - oe_n = we_n = 1.
  - For writes: dq_oe = 1 and o_sram_dq = latched data.
  - Next state: ACCESS, with the wait counter loaded.
- ACCESS (READ_WAIT or WRITE_WAIT cycles):
  - Read: oe_n = 0. Write: we_n = 0, with dq_oe = 1.
  - For reads, i_sram_dq is captured into o_dat on the edge that ends the last ACCESS cycle.
  - Next state: HOLD.
- HOLD (1 cycle):
  - oe_n = we_n = 1; ce_n = 0; address held.
  - For writes, dq_oe stays 1 (data hold after the we_n rise).
  - o_ack = 1 for this cycle only.
  - Next state: WAITREL.
- WAITREL:
  - ce_n = 1, dq_oe = 0.
  - Stay until i_cs is sampled 0, then go to IDLE.
  - A new request is accepted only after i_cs has been seen low for at least one edge; no second ack is issued for a held i_cs.
- Latency, counted from the IDLE edge that samples i_cs = 1:
  - o_ack high in cycle 2+READ_WAIT (read) or 2+WRITE_WAIT (write).
  - o_ack high in cycle 1 for a protected write.
- o_dat: updated only by read captures; holds its value across writes and idle time.
- Abort: i_cs sampled 0 in SETUP or ACCESS:
  - Next cycle goes to IDLE with all strobes high and dq_oe = 0.
  - No ack. An aborted write may leave the SRAM location undefined.
  - o_dat is unchanged.
- Master changeover: i_cs dropping in HOLD has no effect; the ack is still issued.
- i_addr, i_dat and i_we changing while busy are ignored, because the latched copies are used.
- Out-of-range READ_WAIT or WRITE_WAIT: synthesis-time error.

Test Plan:
- Read, READ_WAIT = 2, SRAM model holds 8'hA5 at 16'h1234: i_cs held from edge 0 → ce_n low cycles 1–4, oe_n low cycles 2–3, o_ack = 1 in cycle 4 only, o_dat = 8'hA5; then i_cs low → IDLE.
- Write 8'h3C to 16'h8001, WRITE_WAIT = 3:
  - we_n low exactly cycles 2–4.
  - dq_oe high cycles 1–5, o_sram_dq = 8'h3C.
  - o_ack in cycle 5.
  - Readback returns 8'h3C.
- i_cs held high for 10 cycles after ack → no second access and no second ack. Dropping i_cs for 1 cycle then raising it → a new access starts.
- WP_TOP = 16'h2000:
  - Write 8'hFF to 16'h0100 → o_ack in cycle 1, no strobes, SRAM byte unchanged.
  - Write to 16'h2000 → normal write.
- Abort: drop i_cs in the first ACCESS cycle of a read → strobes high the next cycle, no ack, o_dat keeps its previous value, busy clears.
- Assert i_reset_n = 0 mid-write with we_n low → we_n, ce_n and dq_oe release without waiting for a clock; after release, a read completes normally.
